ram_arbiter: RTL and testbench



---
 rtl/ram_arbiter_pkg.sv | 22 ++
 rtl/ram_arbiter_if.sv | 51 +++++
 rtl/ram_arbiter_rr_arbiter2.sv | 38 +++
 rtl/ram_arbiter.sv | 121 ++++++++++++
 tb/tb_ram_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_arbiter_pkg.sv
// ram_arb_pkg: shared types and constants for the ram_arbiter slice.
//   ram_op_e    - RAM operation encoding driven on mem_operation
//   arb_state_e - access sequencer states
//   REQ_A/REQ_B - requester ids, also used as grant/request vector indices
package ram_arb_pkg;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } ram_op_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        DONE   = 2'd3
    } arb_state_e;

    localparam int REQ_A = 0;
    localparam int REQ_B = 1;

endpackage

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: bundles the two requester ports, the response port and the
// RAM control pins of ram_arbiter.
//   a_req_* / b_req_* - valid/ready request handshake, op, addr, wdata
//   rsp_*             - one-cycle response pulse with id, read data, error
//   mem_*             - RAM address/select/operation/wdata out, rdata in
// Modports: slave = arbiter side, master = client/RAM side.
interface ram_arbiter_if #(
    parameter int WORD_SIZE = 27,
    parameter int AW        = 6
);
    logic                 a_req_valid;
    logic                 a_req_ready;
    logic                 a_req_op;
    logic [AW-1:0]        a_req_addr;
    logic [WORD_SIZE-1:0] a_req_wdata;

    logic                 b_req_valid;
    logic                 b_req_ready;
    logic                 b_req_op;
    logic [AW-1:0]        b_req_addr;
    logic [WORD_SIZE-1:0] b_req_wdata;

    logic                 rsp_valid;
    logic                 rsp_id;
    logic [WORD_SIZE-1:0] rsp_rdata;
    logic                 rsp_err;

    logic [AW-1:0]        mem_address;
    logic                 mem_select;
    logic                 mem_operation;
    logic [WORD_SIZE-1:0] mem_wdata;
    logic [WORD_SIZE-1:0] mem_rdata;

    modport slave (
        input  a_req_valid, a_req_op, a_req_addr, a_req_wdata,
        input  b_req_valid, b_req_op, b_req_addr, b_req_wdata,
        output a_req_ready, b_req_ready,
        output rsp_valid, rsp_id, rsp_rdata, rsp_err,
        output mem_address, mem_select, mem_operation, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output a_req_valid, a_req_op, a_req_addr, a_req_wdata,
        output b_req_valid, b_req_op, b_req_addr, b_req_wdata,
        input  a_req_ready, b_req_ready,
        input  rsp_valid, rsp_id, rsp_rdata, rsp_err,
        input  mem_address, mem_select, mem_operation, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/ram_arbiter_rr_arbiter2.sv
// rr_arbiter2: two-way round-robin arbiter with an internal 1-bit priority
// pointer.
//   clk, rst_n - clock, asynchronous active-low reset (pointer -> A)
//   i_req[1:0] - requests, indexed by REQ_A/REQ_B
//   i_en       - grants only issued while high
//   o_grant    - one-hot (or zero) grant, combinational
// The pointer only arbitrates a tie; a lone request always wins. After any
// grant the pointer moves to the requester that was not granted.
module rr_arbiter2
    import ram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_req,
    input  logic       i_en,
    output logic [1:0] o_grant
);
    logic r_prio;

    always_comb begin
        o_grant = 2'b00;
        if (i_en) begin
            if (i_req == 2'b11) begin
                o_grant[r_prio] = 1'b1;
            end else begin
                o_grant = i_req;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio <= 1'(REQ_A);
        end else if (|o_grant) begin
            r_prio <= o_grant[REQ_A] ? 1'(REQ_B) : 1'(REQ_A);
        end
    end
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: two-port front end for a single-port RAM. Arbitrates A/B
// round-robin and sequences IDLE -> SETUP -> STROBE -> DONE so the RAM sees
// address/operation/wdata settle for a full cycle before select rises.
//   clk, rst_n - clock, asynchronous active-low reset
//   bus        - ram_arbiter_if.slave (requests, response, RAM pins)
// Optional feature: RAM_ARB_BOUNDS_CHECK_EN. When defined, an address at or
// beyond WORD_AMOUNT skips STROBE and is answered with rsp_err; otherwise the
// address is forwarded unchecked and rsp_err is tied low.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int WORD_SIZE   = 27,
    parameter int WORD_AMOUNT = 37
) (
    input  logic          clk,
    input  logic          rst_n,
    ram_arbiter_if.slave  bus
);
    localparam int AW = $clog2(WORD_AMOUNT);

    arb_state_e           r_state;
    logic                 r_id;
    logic [AW-1:0]        r_mem_address;
    logic                 r_mem_select;
    ram_op_e              r_mem_operation;
    logic [WORD_SIZE-1:0] r_mem_wdata;
    logic                 r_rsp_valid;
    logic                 r_rsp_id;
    logic [WORD_SIZE-1:0] r_rsp_rdata;
    logic                 r_rsp_err;

    logic [1:0]           w_req;
    logic [1:0]           w_grant;
    logic                 w_en;
    logic                 w_sel_b;

    assign w_req[REQ_A] = bus.a_req_valid;
    assign w_req[REQ_B] = bus.b_req_valid;
    // Gated by rst_n so ready stays low while reset is held.
    assign w_en    = (r_state == IDLE) && rst_n;
    assign w_sel_b = w_grant[REQ_B];

    rr_arbiter2 u_rr (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_req   (w_req),
        .i_en    (w_en),
        .o_grant (w_grant)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= IDLE;
            r_id            <= 1'b0;
            r_mem_address   <= '0;
            r_mem_select    <= 1'b0;
            r_mem_operation <= READ;
            r_mem_wdata     <= '0;
            r_rsp_valid     <= 1'b0;
            r_rsp_id        <= 1'b0;
            r_rsp_rdata     <= '0;
            r_rsp_err       <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    // The mem_* registers are the request latches, so they
                    // are already driven to the RAM throughout SETUP.
                    if (|w_grant) begin
                        r_id            <= w_sel_b;
                        r_mem_address   <= w_sel_b ? bus.b_req_addr : bus.a_req_addr;
                        r_mem_operation <= ram_op_e'(w_sel_b ? bus.b_req_op : bus.a_req_op);
                        r_mem_wdata     <= w_sel_b ? bus.b_req_wdata : bus.a_req_wdata;
                        r_state         <= SETUP;
                    end
                end
                SETUP: begin
`ifdef RAM_ARB_BOUNDS_CHECK_EN
                    if (32'(r_mem_address) >= WORD_AMOUNT) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_id    <= r_id;
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_mem_select <= 1'b1;
                        r_state      <= STROBE;
                    end
`else
                    r_mem_select <= 1'b1;
                    r_state      <= STROBE;
`endif
                end
                STROBE: begin
                    r_mem_select <= 1'b0;
                    r_rsp_valid  <= 1'b1;
                    r_rsp_id     <= r_id;
                    r_rsp_rdata  <= (r_mem_operation == READ) ? bus.mem_rdata : '0;
                    r_rsp_err    <= 1'b0;
                    r_state      <= DONE;
                end
                DONE: begin
                    r_rsp_err <= 1'b0;
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.a_req_ready   = w_grant[REQ_A];
    assign bus.b_req_ready   = w_grant[REQ_B];
    assign bus.rsp_valid     = r_rsp_valid;
    assign bus.rsp_id        = r_rsp_id;
    assign bus.rsp_rdata     = r_rsp_rdata;
    assign bus.rsp_err       = r_rsp_err;
    assign bus.mem_address   = r_mem_address;
    assign bus.mem_select    = r_mem_select;
    assign bus.mem_operation = r_mem_operation;
    assign bus.mem_wdata     = r_mem_wdata;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed self-checking bench for ram_arbiter. A behavioral
// RAM responds to rising mem_select; unwritten words read as 27'h100000+addr.
module tb_ram_arbiter;
    localparam int WS = 27;
    localparam int AW = 6;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   ncyc;
    int   both_ready;

    ram_arbiter_if #(.WORD_SIZE(WS), .AW(AW)) bus ();

    ram_arbiter #(.WORD_SIZE(WS), .WORD_AMOUNT(37)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioral RAM: access on the rising edge of select.
    logic [WS-1:0] mem_model [0:63];
    bit            written   [0:63];
    always @(posedge bus.mem_select) begin
        if (bus.mem_operation) begin
            mem_model[bus.mem_address] <= bus.mem_wdata;
            written[bus.mem_address]   <= 1'b1;
        end else begin
            bus.mem_rdata <= written[bus.mem_address] ? mem_model[bus.mem_address]
                                                      : (27'h100000 + 27'(bus.mem_address));
        end
    end

    typedef struct {
        int          cyc;
        bit          id;
        logic [WS-1:0] rdata;
        bit          err;
    } rsp_t;

    int   a_acc_q[$];
    int   b_acc_q[$];
    int   sel_q[$];
    rsp_t rsp_q[$];

    // Monitor: records the negedge index of every observed event.
    always @(negedge clk) begin
        if (bus.a_req_ready === 1'b1) a_acc_q.push_back(ncyc);
        if (bus.b_req_ready === 1'b1) b_acc_q.push_back(ncyc);
        if (bus.a_req_ready === 1'b1 && bus.b_req_ready === 1'b1) both_ready++;
        if (bus.mem_select === 1'b1) sel_q.push_back(ncyc);
        if (bus.rsp_valid === 1'b1) begin
            rsp_t r;
            r.cyc = ncyc; r.id = bus.rsp_id; r.rdata = bus.rsp_rdata; r.err = bus.rsp_err;
            rsp_q.push_back(r);
        end
        ncyc++;
    end

    task automatic clear_q();
        a_acc_q.delete(); b_acc_q.delete(); sel_q.delete(); rsp_q.delete();
    endtask

    task automatic idle_inputs();
        bus.a_req_valid = 0; bus.a_req_op = 0; bus.a_req_addr = '0; bus.a_req_wdata = '0;
        bus.b_req_valid = 0; bus.b_req_op = 0; bus.b_req_addr = '0; bus.b_req_wdata = '0;
    endtask

    // Presents one request and waits (bounded) for its ready; acc is the
    // negedge index at which ready was seen.
    task automatic drive_req(input bit id, input bit op, input logic [AW-1:0] addr,
                             input logic [WS-1:0] data, output int acc);
        bit got;
        got = 0;
        acc = -100;
        @(posedge clk); #1;
        if (id == 0) begin
            bus.a_req_valid = 1; bus.a_req_op = op; bus.a_req_addr = addr; bus.a_req_wdata = data;
        end else begin
            bus.b_req_valid = 1; bus.b_req_op = op; bus.b_req_addr = addr; bus.b_req_wdata = data;
        end
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk); #1;
            if ((id == 0 && bus.a_req_ready === 1'b1) || (id == 1 && bus.b_req_ready === 1'b1)) begin
                got = 1;
                acc = ncyc - 1;
            end
        end
        @(posedge clk); #1;
        idle_inputs();
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL accept_timeout id=%0d addr=%0d: no ready within 20 cycles", id, addr);
        end
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle_inputs();
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({bus.a_req_ready, bus.b_req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_err,
             bus.mem_select, bus.mem_operation} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl got=%b want=0000000", {bus.a_req_ready, bus.b_req_ready,
                     bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.mem_select, bus.mem_operation});
        end
        checks++;
        if (bus.mem_address !== '0 || bus.mem_wdata !== '0 || bus.rsp_rdata !== '0) begin
            errors++;
            $display("FAIL reset_data addr=%h wdata=%h rdata=%h want 0", bus.mem_address,
                     bus.mem_wdata, bus.rsp_rdata);
        end
        @(posedge clk); #1;
        rst_n = 1;
        clear_q();
        repeat (20) @(negedge clk);
        #1;
        checks++;
        if (sel_q.size() != 0 || rsp_q.size() != 0) begin
            errors++;
            $display("FAIL reset_idle selects=%0d rsps=%0d want 0/0", sel_q.size(), rsp_q.size());
        end
        $display("test_reset done");
    endtask

    task automatic test_write_read();
        int acc;
        clear_q();
        drive_req(0, 1, 6'd5, 27'h1ABCDEF, acc);
        repeat (5) @(negedge clk);
        #1;
        checks++;
        if (sel_q.size() != 1 || sel_q[0] != acc + 2) begin
            errors++;
            $display("FAIL wr_select count=%0d first=%0d want 1 at %0d", sel_q.size(),
                     (sel_q.size() > 0) ? sel_q[0] : -1, acc + 2);
        end
        checks++;
        if (rsp_q.size() != 1 || rsp_q[0].cyc != acc + 3 || rsp_q[0].id != 0 ||
            rsp_q[0].rdata !== '0 || rsp_q[0].err != 0) begin
            errors++;
            $display("FAIL wr_rsp count=%0d want 1 rsp at %0d id0 rdata0 err0", rsp_q.size(), acc + 3);
        end
        $display("write A addr5 data 1abcdef accepted at %0d", acc);

        clear_q();
        drive_req(0, 0, 6'd5, '0, acc);
        repeat (5) @(negedge clk);
        #1;
        checks++;
        if (rsp_q.size() != 1 || rsp_q[0].cyc != acc + 3 || rsp_q[0].id != 0 ||
            rsp_q[0].rdata !== 27'h1ABCDEF || rsp_q[0].err != 0) begin
            errors++;
            $display("FAIL rd_rsp count=%0d rdata=%h want 1 rsp at %0d id0 rdata 1abcdef",
                     rsp_q.size(), (rsp_q.size() > 0) ? rsp_q[0].rdata : 27'h0, acc + 3);
        end
        $display("read A addr5 accepted at %0d", acc);
    endtask

    task automatic test_contention();
        int s;
        @(posedge clk); #1;
        rst_n = 0;
        #2;
        rst_n = 1;
        clear_q();
        both_ready = 0;
        @(posedge clk); #1;
        bus.a_req_valid = 1; bus.a_req_op = 1; bus.a_req_addr = 6'd10; bus.a_req_wdata = 27'h0AAAAAA;
        bus.b_req_valid = 1; bus.b_req_op = 1; bus.b_req_addr = 6'd11; bus.b_req_wdata = 27'h5555555;
        s = ncyc;
        repeat (14) @(negedge clk);
        @(posedge clk); #1;
        idle_inputs();
        repeat (6) @(negedge clk);
        #1;
        checks++;
        if (a_acc_q.size() != 2 || a_acc_q[0] != s || a_acc_q[1] != s + 8) begin
            errors++;
            $display("FAIL cont_a_grants count=%0d want A at %0d,%0d", a_acc_q.size(), s, s + 8);
        end
        checks++;
        if (b_acc_q.size() != 2 || b_acc_q[0] != s + 4 || b_acc_q[1] != s + 12) begin
            errors++;
            $display("FAIL cont_b_grants count=%0d want B at %0d,%0d", b_acc_q.size(), s + 4, s + 12);
        end
        checks++;
        if (rsp_q.size() != 4 || rsp_q[0].id != 0 || rsp_q[1].id != 1 ||
            rsp_q[2].id != 0 || rsp_q[3].id != 1 || rsp_q[0].err || rsp_q[3].err) begin
            errors++;
            $display("FAIL cont_rsp_ids count=%0d want 4 ids 0,1,0,1 err0", rsp_q.size());
        end
        checks++;
        if (both_ready != 0) begin
            errors++;
            $display("FAIL cont_onehot both_ready_cycles=%0d want 0", both_ready);
        end
        $display("contention from %0d grants A=%0d B=%0d", s, a_acc_q.size(), b_acc_q.size());
    endtask

    task automatic test_lone();
        int s;
        clear_q();
        @(posedge clk); #1;
        bus.b_req_valid = 1; bus.b_req_op = 0; bus.b_req_addr = 6'd11; bus.b_req_wdata = '0;
        s = ncyc;
        repeat (6) @(negedge clk);
        @(posedge clk); #1;
        idle_inputs();
        repeat (6) @(negedge clk);
        #1;
        checks++;
        if (b_acc_q.size() != 2 || b_acc_q[0] != s || b_acc_q[1] != s + 4) begin
            errors++;
            $display("FAIL lone_b_grants count=%0d want B at %0d,%0d", b_acc_q.size(), s, s + 4);
        end
        checks++;
        if (a_acc_q.size() != 0) begin
            errors++;
            $display("FAIL lone_a_ready count=%0d want 0", a_acc_q.size());
        end
        checks++;
        if (rsp_q.size() != 2 || rsp_q[0].id != 1 || rsp_q[1].id != 1 ||
            rsp_q[0].rdata !== 27'h5555555 || rsp_q[1].rdata !== 27'h5555555) begin
            errors++;
            $display("FAIL lone_rsp count=%0d want 2 id1 rdata 5555555", rsp_q.size());
        end
        $display("lone B from %0d grants=%0d", s, b_acc_q.size());
    endtask

    task automatic test_reset_mid_op();
        int acc;
        clear_q();
        drive_req(0, 1, 6'd7, 27'h0765432, acc);
        @(negedge clk);
        @(negedge clk);
        #1;
        rst_n = 0;
        #1;
        checks++;
        if (bus.mem_select !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.mem_address !== '0) begin
            errors++;
            $display("FAIL rst_strobe_clear sel=%b rsp=%b addr=%h want 0", bus.mem_select,
                     bus.rsp_valid, bus.mem_address);
        end
        #1;
        rst_n = 1;
        repeat (6) @(negedge clk);
        #1;
        checks++;
        if (sel_q.size() != 1 || rsp_q.size() != 0) begin
            errors++;
            $display("FAIL rst_strobe_rsp selects=%0d rsps=%0d want 1/0", sel_q.size(), rsp_q.size());
        end
        clear_q();
        drive_req(0, 0, 6'd7, '0, acc);
        repeat (5) @(negedge clk);
        #1;
        checks++;
        if (rsp_q.size() != 1 || rsp_q[0].rdata !== 27'h0765432) begin
            errors++;
            $display("FAIL rst_strobe_commit rdata=%h want 0765432",
                     (rsp_q.size() > 0) ? rsp_q[0].rdata : 27'h0);
        end
        $display("reset during strobe write addr7 checked");

        clear_q();
        drive_req(0, 1, 6'd8, 27'h7000008, acc);
        @(negedge clk);
        #1;
        rst_n = 0;
        #2;
        rst_n = 1;
        repeat (6) @(negedge clk);
        #1;
        checks++;
        if (sel_q.size() != 0 || rsp_q.size() != 0) begin
            errors++;
            $display("FAIL rst_setup_abort selects=%0d rsps=%0d want 0/0", sel_q.size(), rsp_q.size());
        end
        clear_q();
        drive_req(0, 0, 6'd8, '0, acc);
        repeat (5) @(negedge clk);
        #1;
        checks++;
        if (rsp_q.size() != 1 || rsp_q[0].rdata !== 27'h100008) begin
            errors++;
            $display("FAIL rst_setup_old rdata=%h want 0100008",
                     (rsp_q.size() > 0) ? rsp_q[0].rdata : 27'h0);
        end
        $display("reset during setup write addr8 checked");
    endtask

`ifdef RAM_ARB_BOUNDS_CHECK_EN
    task automatic test_bounds();
        int acc;
        clear_q();
        drive_req(0, 1, 6'd40, 27'h7FFFFFF, acc);
        repeat (6) @(negedge clk);
        #1;
        checks++;
        if (sel_q.size() != 0) begin
            errors++;
            $display("FAIL oob_select count=%0d want 0", sel_q.size());
        end
        checks++;
        if (rsp_q.size() != 1 || rsp_q[0].cyc != acc + 2 || rsp_q[0].err != 1 ||
            rsp_q[0].rdata !== '0) begin
            errors++;
            $display("FAIL oob_rsp count=%0d want 1 rsp at %0d err1 rdata0", rsp_q.size(), acc + 2);
        end
        clear_q();
        drive_req(0, 0, 6'd3, '0, acc);
        repeat (5) @(negedge clk);
        #1;
        checks++;
        if (rsp_q.size() != 1 || rsp_q[0].rdata !== 27'h100003 || rsp_q[0].err != 0) begin
            errors++;
            $display("FAIL oob_alias rdata=%h want 0100003 err0",
                     (rsp_q.size() > 0) ? rsp_q[0].rdata : 27'h0);
        end
        $display("out-of-range write addr40 checked");
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        ncyc = 0;
        both_ready = 0;
        test_reset();
        test_write_read();
        test_contention();
        test_lone();
        test_reset_mid_op();
`ifdef RAM_ARB_BOUNDS_CHECK_EN
        test_bounds();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
